p_reduce_seq: RTL and testbench

Sequential multi-operand bitwise reducer. Operand buses arrive one per cycle over a valid/ready stream instead of side by side in a parallel array. The block folds NB_INS operands with a selectable bitwise operation (AND/OR/XOR and their inversions, including NOR) and presents one result over a valid/ready output. It serves as the serial counterpart to the parallel boolean reduction gates when operands come off a shared bus.

---
 rtl/p_reduce_seq.sv | 123 ++++++++++++
 tb/tb_p_reduce_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/p_reduce_seq.sv
// Serial bitwise reducer: folds NB_INS operands taken one per cycle over a
// valid/ready stream and presents the AND/OR/XOR (optionally inverted) result.
module p_reduce_seq #(
  parameter int BUS_WIDTH = 4,
  parameter int NB_INS    = 3,
  localparam int CNT_W    = $clog2(NB_INS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [2:0]           op,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_bus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_bus,
  output logic                 out_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [BUS_WIDTH-1:0] r_acc;
  logic [BUS_WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [2:0]           r_op;
  logic [2:0]           w_op_next;
  logic                 w_accept;
  logic [BUS_WIDTH-1:0] w_combined;
  logic [BUS_WIDTH-1:0] w_result;

  // in_ready is gated by rst_n so it reads low for the whole reset pulse.
  assign in_ready  = rst_n & (r_state != ST_DONE);
  assign w_accept  = in_valid & in_ready & ~clear;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_combined = r_acc & in_bus;
    case (r_op)
      3'b000, 3'b011: w_combined = r_acc & in_bus;
      3'b001, 3'b100: w_combined = r_acc | in_bus;
      3'b010, 3'b101: w_combined = r_acc ^ in_bus;
      default:        w_combined = r_acc & in_bus;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (r_op)
      3'b000, 3'b001, 3'b010: w_result = r_acc;
      3'b011, 3'b100, 3'b101: w_result = ~r_acc;
      default:                w_result = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_op_next    = r_op;
    if (clear) begin
      w_state_next = ST_IDLE;
      w_acc_next   = '0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_op_next    = op;
            w_acc_next   = in_bus;
            w_cnt_next   = CNT_W'(1);
            w_state_next = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            w_acc_next = w_combined;
            w_cnt_next = w_cnt_inc;
            if (w_cnt_inc == CNT_W'(NB_INS)) begin
              w_state_next = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_op    <= w_op_next;
    end
  end

  assign out_valid = (r_state == ST_DONE);
  assign out_bus   = out_valid ? w_result : '0;
  assign out_err   = out_valid & (r_op[2:1] == 2'b11);
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_p_reduce_seq.sv
// Directed bench for p_reduce_seq with hand-computed expected results.
module tb_p_reduce_seq;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [2:0] op;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_bus;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_bus;
  logic       out_err;
  logic       busy;

  int n_checks;
  int n_errors;

  p_reduce_seq #(.BUS_WIDTH(4), .NB_INS(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .op       (op),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bus   (in_bus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bus  (out_bus),
    .out_err  (out_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand for a single edge; back-to-back calls keep in_valid high.
  task automatic send(input logic [3:0] v);
    in_valid = 1'b1;
    in_bus   = v;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    op        = 3'b000;
    in_valid  = 1'b0;
    in_bus    = 4'h0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // NOR back-to-back: ~(1001|1011|1011) = 0100
    op = 3'b100;
    send(4'b1001);
    send(4'b1011);
    check("nor_not_yet", {31'd0, out_valid}, 32'd0);
    send(4'b1011);
    check("nor_valid", {31'd0, out_valid}, 32'd1);
    check("nor_bus", {28'd0, out_bus}, 32'b0100);
    check("nor_err", {31'd0, out_err}, 32'd0);
    check("nor_in_ready_done", {31'd0, in_ready}, 32'd0);
    step();
    check("nor_drop", {31'd0, out_valid}, 32'd0);
    check("nor_idle_busy", {31'd0, busy}, 32'd0);

    // XOR with a gap and op change: 1100^1010^0110 = 0000
    op = 3'b010;
    send(4'b1100);
    op = 3'b000;
    step();
    step();
    check("xor_gap_hold", {31'd0, busy}, 32'd1);
    send(4'b1010);
    send(4'b0110);
    check("xor_valid", {31'd0, out_valid}, 32'd1);
    check("xor_bus", {28'd0, out_bus}, 32'b0000);
    step();

    // AND with back-pressure: 1111&1110&0111 = 0110
    out_ready = 1'b0;
    op = 3'b000;
    send(4'b1111);
    send(4'b1110);
    send(4'b0111);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("and_hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("and_hold_bus%0d", i), {28'd0, out_bus}, 32'b0110);
      check($sformatf("and_hold_ready%0d", i), {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("and_after_hs_valid", {31'd0, out_valid}, 32'd0);
    check("and_after_hs_ready", {31'd0, in_ready}, 32'd1);

    // NAND aborted by clear with a same-cycle operand
    op = 3'b011;
    send(4'b1111);
    send(4'b1111);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_bus   = 4'b1111;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("clr_valid_later", {31'd0, out_valid}, 32'd0);
    send(4'b1111);
    send(4'b1111);
    check("nand_partial", {31'd0, out_valid}, 32'd0);
    send(4'b1111);
    check("nand_valid", {31'd0, out_valid}, 32'd1);
    check("nand_bus", {28'd0, out_bus}, 32'b0000);
    step();

    // Reserved op flags an error and forces zero
    op = 3'b111;
    send(4'b0001);
    send(4'b0010);
    send(4'b0100);
    check("rsv_valid", {31'd0, out_valid}, 32'd1);
    check("rsv_bus", {28'd0, out_bus}, 32'b0000);
    check("rsv_err", {31'd0, out_err}, 32'd1);
    step();
    op = 3'b001;
    send(4'b0001);
    send(4'b0010);
    send(4'b0100);
    check("or_bus", {28'd0, out_bus}, 32'b0111);
    check("or_err", {31'd0, out_err}, 32'd0);
    step();

    // Asynchronous reset in ACCUM
    op = 3'b000;
    send(4'b1010);
    #2 rst_n = 1'b0;
    #1;
    check("arst_accum_busy", {31'd0, busy}, 32'd0);
    check("arst_accum_ready", {31'd0, in_ready}, 32'd0);
    #3 rst_n = 1'b1;
    step();

    // Asynchronous reset in DONE under back-pressure
    out_ready = 1'b0;
    op = 3'b100;
    send(4'b0001);
    send(4'b0001);
    send(4'b0001);
    check("pre_arst_done_bus", {28'd0, out_bus}, 32'b1110);
    #2 rst_n = 1'b0;
    #1;
    check("arst_done_valid", {31'd0, out_valid}, 32'd0);
    check("arst_done_bus", {28'd0, out_bus}, 32'd0);
    check("arst_done_err", {31'd0, out_err}, 32'd0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // NOR of zeros after reset release: 1111
    op = 3'b100;
    send(4'b0000);
    send(4'b0000);
    send(4'b0000);
    check("nor0_valid", {31'd0, out_valid}, 32'd1);
    check("nor0_bus", {28'd0, out_bus}, 32'b1111);
    step();
    check("final_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
